writeback_arbiter: RTL
======================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_UNITS, default 4, meaning the number of functional units (unit id width 2).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the result width.
REQ-003 The block SHALL have port clock  in  1  the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port fu_valid  in  NUM_UNITS  one bit per unit: result offered.
REQ-006 The block SHALL have port fu_ready  out  NUM_UNITS  one bit per unit: holding slot can accept.
REQ-007 The block SHALL have port fu_addr  in  NUM_UNITS*5  destination register per unit.
REQ-008 The block SHALL have port fu_row  in  NUM_UNITS*5  data-position tag per unit.
REQ-009 The block SHALL have port fu_data  in  NUM_UNITS*DATA_W  result per unit.
REQ-010 The block SHALL have port sb_query_addr  out  5  scoreboard asynchronous read address.
REQ-011 The block SHALL have ports sb_pending  in  1, sb_unit  in  2, sb_row  in  5  scoreboard read response for sb_query_addr.
REQ-012 The block SHALL have ports wb_valid  out  1, wb_addr  out  5, wb_unit  out  2, wb_data  out  DATA_W  registered result broadcast.
REQ-013 The block SHALL have ports clear_enable  out  1, clear_addr  out  5  registered scoreboard pending-clear request.

Function
REQ-014 Each unit SHALL own one holding slot (valid, addr, row, data); fu_ready[u] = ~slot_valid[u] | grant[u].
REQ-015 A slot SHALL load on a rising edge where fu_valid[u] & fu_ready[u]; freeing and refilling one slot in the same edge SHALL be allowed.
REQ-016 Grant SHALL be combinational round-robin over valid slots, searching from rr_ptr upward with wrap-around from NUM_UNITS-1 to 0; at most one grant per cycle.
REQ-017 On an edge with a grant, rr_ptr SHALL become (granted unit + 1) mod NUM_UNITS; with no grant rr_ptr SHALL hold.
REQ-018 sb_query_addr SHALL equal the granted slot's addr, or 0 with no grant.
REQ-019 On an edge with a grant to unit u with addr != 0, wb_valid SHALL be 1 next cycle with wb_addr/wb_unit/wb_data from the slot; otherwise wb_valid SHALL be 0.
REQ-020 Latency SHALL be exactly 1 cycle from slot load to earliest wb_valid (slot loaded edge N, broadcast visible after edge N+1).
REQ-021 Results to register 0 SHALL be granted and freed normally but SHALL produce neither wb_valid nor clear_enable.
REQ-022 clear_enable SHALL be registered with wb_valid, clear_addr = wb_addr; its condition is set by REQ-027.
REQ-023 With all slots empty, wb_valid and clear_enable SHALL be 0 the following cycle; with all slots full, only the granted unit SHALL see fu_ready=1.

Reset
REQ-024 While reset is high: all slot_valid, wb_valid, clear_enable SHALL be 0; wb_addr, wb_unit, wb_data, clear_addr SHALL be 0; rr_ptr SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL discard all held results without broadcast or clear.
REQ-026 fu_ready SHALL be all ones immediately after reset deasserts.

Configuration
REQ-027 Macro SCOREBOARD_OWNER_CHECK_EN: when defined, clear_enable SHALL assert only if sb_pending=1, sb_unit=u and sb_row=slot row at grant time (stale WAW results broadcast without clearing); when undefined, clear_enable SHALL equal wb_valid and sb_query_addr SHALL be driven 0.

Structure
REQ-028 A shared package SHALL hold REG_ADDR_W=5, UNIT_W=2, ROW_W=5 and the unit-id constants (ALU=0, MEM=1, MUL=2, DIV=3) used by the scoreboard and this block.
REQ-029 The round-robin grant logic SHALL be one sub-module, rr_arbiter (request, pointer in; one-hot grant out).

Verification
REQ-030 Unit 1 offers addr 4, row 3, data 0xDEAD; scoreboard holds reg 4 pending, unit 1, row 3 -> one cycle later wb_valid=1, wb_addr=4, wb_unit=1, clear_enable=1, clear_addr=4.
REQ-031 Units 0..3 all offer in one cycle (addrs 1..4), rr_ptr=0 -> broadcasts in order 1,2,3,4 on four consecutive cycles, each fu_ready rising as its slot drains.
REQ-032 With SCOREBOARD_OWNER_CHECK_EN, unit 2 returns reg 7 while scoreboard reg 7 owned by unit 1 -> wb_valid=1, clear_enable=0; without the macro -> clear_enable=1.
REQ-033 Unit 0 offers addr 0 -> slot frees, wb_valid=0, clear_enable=0, rr_ptr advances to 1.
REQ-034 Reset pulsed while three slots are full -> no broadcast follows, fu_ready=4'b1111, first post-reset grant goes to lowest valid unit.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// Shared widths and functional-unit ids used by the scoreboard and the writeback arbiter.
package writeback_arbiter_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned UNIT_W     = 2;
   localparam int unsigned ROW_W      = 5;

   typedef enum logic [UNIT_W-1:0] {
      UnitAlu = 2'd0,
      UnitMem = 2'd1,
      UnitMul = 2'd2,
      UnitDiv = 2'd3
   } unit_id_e;

   localparam logic [UNIT_W-1:0] ALU = UnitAlu;
   localparam logic [UNIT_W-1:0] MEM = UnitMem;
   localparam logic [UNIT_W-1:0] MUL = UnitMul;
   localparam logic [UNIT_W-1:0] DIV = UnitDiv;

endpackage

// File: rtl/writeback_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i, wrapping to 0.
module rr_arbiter #(
   parameter int unsigned N    = 4,
   parameter int unsigned PtrW = 2
) (
   input  logic [N-1:0]    req_i,
   input  logic [PtrW-1:0] ptr_i,
   output logic [N-1:0]    grant_o
);

   int              pos;
   logic [PtrW-1:0] sel;
   logic            found;

   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      pos     = 0;
      sel     = '0;
      for (int k = 0; k < int'(N); k++) begin
         pos = int'(ptr_i) + k;
         if (pos >= int'(N)) pos = pos - int'(N);
         sel = PtrW'(pos);
         if (!found && req_i[sel]) begin
            grant_o[sel] = 1'b1;
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: one holding slot per unit, round-robin drain to a registered broadcast.
// Optional owner check on scoreboard clears is enabled by defining SCOREBOARD_OWNER_CHECK_EN.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int unsigned NUM_UNITS = 4,
   parameter int unsigned DATA_W    = 32
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_UNITS-1:0]             fu_valid,
   output logic [NUM_UNITS-1:0]             fu_ready,
   input  logic [NUM_UNITS*REG_ADDR_W-1:0]  fu_addr,
   input  logic [NUM_UNITS*ROW_W-1:0]       fu_row,
   input  logic [NUM_UNITS*DATA_W-1:0]      fu_data,
   output logic [REG_ADDR_W-1:0]            sb_query_addr,
   input  logic                             sb_pending,
   input  logic [UNIT_W-1:0]                sb_unit,
   input  logic [ROW_W-1:0]                 sb_row,
   output logic                             wb_valid,
   output logic [REG_ADDR_W-1:0]            wb_addr,
   output logic [UNIT_W-1:0]                wb_unit,
   output logic [DATA_W-1:0]                wb_data,
   output logic                             clear_enable,
   output logic [REG_ADDR_W-1:0]            clear_addr
);

   logic [NUM_UNITS-1:0]  slot_valid_q, slot_valid_d;
   logic [REG_ADDR_W-1:0] slot_addr_q [NUM_UNITS];
   logic [REG_ADDR_W-1:0] slot_addr_d [NUM_UNITS];
   logic [ROW_W-1:0]      slot_row_q  [NUM_UNITS];
   logic [ROW_W-1:0]      slot_row_d  [NUM_UNITS];
   logic [DATA_W-1:0]     slot_data_q [NUM_UNITS];
   logic [DATA_W-1:0]     slot_data_d [NUM_UNITS];

   logic [UNIT_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic                  wb_valid_q, wb_valid_d;
   logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
   logic [UNIT_W-1:0]     wb_unit_q, wb_unit_d;
   logic [DATA_W-1:0]     wb_data_q, wb_data_d;
   logic                  clear_q, clear_d;

   logic [NUM_UNITS-1:0]  grant;
   logic                  grant_any;
   logic [UNIT_W-1:0]     grant_idx;
   logic [REG_ADDR_W-1:0] g_addr;
   logic [ROW_W-1:0]      g_row;
   logic [DATA_W-1:0]     g_data;

   rr_arbiter #(
      .N    (NUM_UNITS),
      .PtrW (UNIT_W)
   ) u_rr_arbiter (
      .req_i   (slot_valid_q),
      .ptr_i   (rr_ptr_q),
      .grant_o (grant)
   );

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int u = 0; u < int'(NUM_UNITS); u++) begin
         if (grant[u]) begin
            grant_any = 1'b1;
            grant_idx = UNIT_W'(u);
         end
      end
   end

   assign g_addr   = slot_addr_q[grant_idx];
   assign g_row    = slot_row_q[grant_idx];
   assign g_data   = slot_data_q[grant_idx];
   assign fu_ready = ~slot_valid_q | grant;

   // A granted slot frees and may be refilled on the same edge.
   always_comb begin
      for (int u = 0; u < int'(NUM_UNITS); u++) begin
         slot_valid_d[u] = slot_valid_q[u];
         slot_addr_d[u]  = slot_addr_q[u];
         slot_row_d[u]   = slot_row_q[u];
         slot_data_d[u]  = slot_data_q[u];
         if (grant[u]) slot_valid_d[u] = 1'b0;
         if (fu_valid[u] && fu_ready[u]) begin
            slot_valid_d[u] = 1'b1;
            slot_addr_d[u]  = fu_addr[u*REG_ADDR_W +: REG_ADDR_W];
            slot_row_d[u]   = fu_row[u*ROW_W +: ROW_W];
            slot_data_d[u]  = fu_data[u*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_any) begin
         rr_ptr_d = (int'(grant_idx) == int'(NUM_UNITS) - 1) ? '0 : grant_idx + 1'b1;
      end
   end

   // Register 0 results drain silently.
   always_comb begin
      wb_valid_d = grant_any && (g_addr != '0);
      wb_addr_d  = wb_addr_q;
      wb_unit_d  = wb_unit_q;
      wb_data_d  = wb_data_q;
      if (wb_valid_d) begin
         wb_addr_d = g_addr;
         wb_unit_d = grant_idx;
         wb_data_d = g_data;
      end
   end

`ifdef SCOREBOARD_OWNER_CHECK_EN
   assign sb_query_addr = grant_any ? g_addr : '0;
   // A stale WAW result still broadcasts but must not clear a newer owner's pending bit.
   assign clear_d = wb_valid_d && sb_pending && (sb_unit == grant_idx) && (sb_row == g_row);
`else
   logic unused_sb;
   assign unused_sb     = ^{sb_pending, sb_unit, sb_row, g_row};
   assign sb_query_addr = '0;
   assign clear_d       = wb_valid_d;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         slot_valid_q <= '0;
         for (int u = 0; u < int'(NUM_UNITS); u++) begin
            slot_addr_q[u] <= '0;
            slot_row_q[u]  <= '0;
            slot_data_q[u] <= '0;
         end
         rr_ptr_q   <= '0;
         wb_valid_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_unit_q  <= '0;
         wb_data_q  <= '0;
         clear_q    <= 1'b0;
      end else begin
         slot_valid_q <= slot_valid_d;
         for (int u = 0; u < int'(NUM_UNITS); u++) begin
            slot_addr_q[u] <= slot_addr_d[u];
            slot_row_q[u]  <= slot_row_d[u];
            slot_data_q[u] <= slot_data_d[u];
         end
         rr_ptr_q   <= rr_ptr_d;
         wb_valid_q <= wb_valid_d;
         wb_addr_q  <= wb_addr_d;
         wb_unit_q  <= wb_unit_d;
         wb_data_q  <= wb_data_d;
         clear_q    <= clear_d;
      end
   end

   assign wb_valid     = wb_valid_q;
   assign wb_addr      = wb_addr_q;
   assign wb_unit      = wb_unit_q;
   assign wb_data      = wb_data_q;
   assign clear_enable = clear_q;
   assign clear_addr   = wb_addr_q;

endmodule
